countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_defs.sv | 18 +
 rtl/countdown_core.sv | 43 ++++
 rtl/countdown_timer.sv | 140 ++++++++++++++
 tb/tb_countdown_timer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_defs.sv
// timer_defs: shared state encodings for countdown_timer.
// The numeric state codes are the ones seen on the countdown_timer
// 'state' output, so testbenches import this package to decode it.
package timer_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_HOLD = ST_HOLD,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/countdown_core.sv
// countdown_core: loadable, holdable down-count register with zero detect.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset, clears the count
//   i_clear     synchronous clear of the count
//   i_load      load i_load_val into the count
//   i_load_val  value loaded on i_load
//   i_dec       decrement request; never takes the count below zero
//   o_count     registered count
//   o_zero      count == 0
//   o_one       count == 1 (the next decrement reaches zero)
// Priority: reset/clear, then load, then decrement.
module countdown_core #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero,
  output logic             o_one
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
  assign o_one   = (r_count == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: FSM-controlled countdown timer with hold, abort and
// optional auto-reload of the last loaded value.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     load load_val and begin counting (accepted in IDLE/DONE only)
//   load_val  start value, sampled on an accepted start
//   hold      freezes the countdown while high
//   abort     cancels any countdown, returns to IDLE with count=0
//   count     registered current count
//   busy      registered, high in RUN and HOLD
//   done      registered, high exactly while in DONE (one cycle per expiry)
//   state     registered FSM state (timer_defs encodings)
// Per-edge priority: rst, abort, start, hold, decrement.
module countdown_timer
  import timer_defs::*;
#(
  parameter int WIDTH  = 4,
  parameter bit RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_reload;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic             w_clear;
  logic             w_dec;
  logic [WIDTH-1:0] w_count;
  logic             w_zero;
  logic             w_one;

  // Datapath control. A start is only accepted when no countdown is in
  // progress; in DONE without a start the reload value is re-armed when
  // auto-reload is enabled, otherwise the count is cleared.
  always_comb begin
    w_accept   = 1'b0;
    w_load     = 1'b0;
    w_load_val = r_reload;
    w_clear    = 1'b0;
    w_dec      = 1'b0;
    if (abort) begin
      w_clear = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_accept = start;
        end
        S_DONE: begin
          w_accept = start;
          if (!start) begin
            w_load  = RELOAD;
            w_clear = !RELOAD;
          end
        end
        S_RUN:   w_dec = !hold;
        default: ;
      endcase
    end
    if (w_accept) begin
      w_load     = 1'b1;
      w_load_val = load_val;
    end
  end

  // Next-state logic. A load of zero expires immediately.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) w_next = (w_load_val == '0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (hold)                w_next = S_HOLD;
          else if (w_one || w_zero) w_next = S_DONE;
        end
        S_HOLD: begin
          if (!hold) w_next = S_RUN;
        end
        S_DONE: begin
          if (w_load) w_next = (w_load_val == '0) ? S_DONE : S_RUN;
          else        w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_reload <= load_val;
      r_busy  <= (w_next == S_RUN) || (w_next == S_HOLD);
      r_done  <= (w_next == S_DONE);
    end
  end

  countdown_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (w_clear),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_zero     (w_zero),
    .o_one      (w_one)
  );

  assign count = w_count;
  assign busy  = r_busy;
  assign done  = r_done;
  assign state = r_state;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven bench for countdown_timer.
// Two instances share the stimulus: u_dut0 (RELOAD=0) and u_dut1 (RELOAD=1).
// Each table row is one clock edge; the row selects which instance is checked.
module tb_countdown_timer;
  import timer_defs::*;

  localparam int W = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         hold = 1'b0;
  logic         abort = 1'b0;

  logic [W-1:0] count0, count1;
  logic         busy0, busy1, done0, done1;
  logic [1:0]   state0, state1;

  countdown_timer #(.WIDTH(W), .RELOAD(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .hold(hold),
    .abort(abort), .count(count0), .busy(busy0), .done(done0), .state(state0)
  );

  countdown_timer #(.WIDTH(W), .RELOAD(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .hold(hold),
    .abort(abort), .count(count1), .busy(busy1), .done(done1), .state(state1)
  );

  typedef struct {
    string        name;
    logic         sel;
    logic         rst;
    logic         start;
    logic [W-1:0] lv;
    logic         hold;
    logic         abort;
    logic [W-1:0] cnt;
    logic [1:0]   st;
    logic         dn;
  } vec_t;

  vec_t vecs[$];

  // Scoreboard: packed {count, state, done, busy}
  logic [7:0] exp_q[$];
  logic       sel_q[$];
  string      name_q[$];
  int         checks = 0;
  int         failures = 0;

  function automatic logic [7:0] pack(logic [W-1:0] c, logic [1:0] s, logic d);
    logic b;
    b = (s == ST_RUN) || (s == ST_HOLD);
    return {c, s, d, b};
  endfunction

  task automatic add(string nm, logic sel, logic r, logic s, int lv, logic h,
                     logic a, int cnt, logic [1:0] st, logic dn);
    vec_t v;
    v.name = nm; v.sel = sel; v.rst = r; v.start = s; v.lv = W'(lv);
    v.hold = h; v.abort = a; v.cnt = W'(cnt); v.st = st; v.dn = dn;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    logic [7:0] exp_v, act_v;
    logic       sel;
    string      nm;
    exp_v = exp_q.pop_front();
    sel   = sel_q.pop_front();
    nm    = name_q.pop_front();
    act_v = sel ? {count1, state1, done1, busy1} : {count0, state0, done0, busy0};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s (dut%0d): got count=%0d state=%0d done=%0b busy=%0b, expected count=%0d state=%0d done=%0b busy=%0b",
               nm, sel, act_v[7:4], act_v[3:2], act_v[1], act_v[0],
               exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask

  // Driver: apply one row for one edge, sample #1 after that edge.
  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; start = v.start; load_val = v.lv; hold = v.hold; abort = v.abort;
    exp_q.push_back(pack(v.cnt, v.st, v.dn));
    sel_q.push_back(v.sel);
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic run_table();
    foreach (vecs[i]) step(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    int n;
    int ns[3];

    //   name         sel rst st  lv  hd ab  cnt state    done
    add("reset",       0, 1, 0,  0, 0, 0,   0, ST_IDLE, 0);
    add("idle_hold",   0, 0, 0,  7, 0, 0,   0, ST_IDLE, 0);
    // load 5: 5,4,3,2,1,0 with done on edge 5 only
    add("l5_e0",       0, 0, 1,  5, 0, 0,   5, ST_RUN,  0);
    add("l5_e1",       0, 0, 0,  0, 0, 0,   4, ST_RUN,  0);
    add("l5_e2",       0, 0, 0,  0, 0, 0,   3, ST_RUN,  0);
    add("l5_e3",       0, 0, 0,  0, 0, 0,   2, ST_RUN,  0);
    add("l5_e4",       0, 0, 0,  0, 0, 0,   1, ST_RUN,  0);
    add("l5_e5",       0, 0, 0,  0, 0, 0,   0, ST_DONE, 1);
    add("l5_after",    0, 0, 0,  0, 0, 0,   0, ST_IDLE, 0);
    add("l5_after2",   0, 0, 0,  0, 0, 0,   0, ST_IDLE, 0);
    // load 3, hold at count 2: 3,2,2,2,1,0, done two edges late
    add("h3_e0",       0, 0, 1,  3, 0, 0,   3, ST_RUN,  0);
    add("h3_e1",       0, 0, 0,  0, 0, 0,   2, ST_RUN,  0);
    add("h3_hold",     0, 0, 0,  0, 1, 0,   2, ST_HOLD, 0);
    add("h3_resume",   0, 0, 0,  0, 0, 0,   2, ST_RUN,  0);
    add("h3_e4",       0, 0, 0,  0, 0, 0,   1, ST_RUN,  0);
    add("h3_e5",       0, 0, 0,  0, 0, 0,   0, ST_DONE, 1);
    add("h3_idle",     0, 0, 0,  0, 0, 0,   0, ST_IDLE, 0);
    // long hold with an ignored start while in HOLD
    add("hl_e0",       0, 0, 1,  2, 0, 0,   2, ST_RUN,  0);
    add("hl_hold1",    0, 0, 0,  0, 1, 0,   2, ST_HOLD, 0);
    add("hl_hold2",    0, 0, 0,  0, 1, 0,   2, ST_HOLD, 0);
    add("hl_start",    0, 0, 1,  7, 1, 0,   2, ST_HOLD, 0);
    add("hl_resume",   0, 0, 0,  0, 0, 0,   2, ST_RUN,  0);
    add("hl_dec",      0, 0, 0,  0, 0, 0,   1, ST_RUN,  0);
    add("hl_done",     0, 0, 0,  0, 0, 0,   0, ST_DONE, 1);
    add("hl_idle",     0, 0, 0,  0, 0, 0,   0, ST_IDLE, 0);
    // abort at count 2 of a load-4 countdown
    add("ab_e0",       0, 0, 1,  4, 0, 0,   4, ST_RUN,  0);
    add("ab_e1",       0, 0, 0,  0, 0, 0,   3, ST_RUN,  0);
    add("ab_e2",       0, 0, 0,  0, 0, 0,   2, ST_RUN,  0);
    add("ab_abort",    0, 0, 0,  0, 0, 1,   0, ST_IDLE, 0);
    add("ab_nodone",   0, 0, 0,  0, 0, 0,   0, ST_IDLE, 0);
    // start 9 during a load-4 run is ignored; done 4 edges after start
    add("ig_e0",       0, 0, 1,  4, 0, 0,   4, ST_RUN,  0);
    add("ig_start9",   0, 0, 1,  9, 0, 0,   3, ST_RUN,  0);
    add("ig_e2",       0, 0, 0,  0, 0, 0,   2, ST_RUN,  0);
    add("ig_e3",       0, 0, 0,  0, 0, 0,   1, ST_RUN,  0);
    add("ig_e4",       0, 0, 0,  0, 0, 0,   0, ST_DONE, 1);
    add("ig_idle",     0, 0, 0,  0, 0, 0,   0, ST_IDLE, 0);
    // load 0 expires on the next edge; rst in DONE clears done
    add("z_start",     0, 0, 1,  0, 0, 0,   0, ST_DONE, 1);
    add("z_rst",       0, 1, 0,  0, 0, 0,   0, ST_IDLE, 0);
    // start from DONE behaves like start from IDLE
    add("dn_e0",       0, 0, 1,  1, 0, 0,   1, ST_RUN,  0);
    add("dn_e1",       0, 0, 0,  0, 0, 0,   0, ST_DONE, 1);
    add("dn_restart",  0, 0, 1,  2, 0, 0,   2, ST_RUN,  0);
    add("dn_dec",      0, 0, 0,  0, 0, 0,   1, ST_RUN,  0);
    add("dn_done",     0, 0, 0,  0, 0, 0,   0, ST_DONE, 1);
    // abort in DONE, priority checks
    add("ad_abort",    0, 0, 1,  3, 0, 1,   0, ST_IDLE, 0);
    add("rs_start",    0, 1, 1,  6, 0, 0,   0, ST_IDLE, 0);
    add("mid_e0",      0, 0, 1,  3, 0, 0,   3, ST_RUN,  0);
    add("mid_rst",     0, 1, 0,  0, 0, 0,   0, ST_IDLE, 0);
    // auto-reload instance: load 2 gives 2,1,0,2,1,0
    add("rl_rst",      1, 1, 0,  0, 0, 0,   0, ST_IDLE, 0);
    add("rl_e0",       1, 0, 1,  2, 0, 0,   2, ST_RUN,  0);
    add("rl_e1",       1, 0, 0,  0, 0, 0,   1, ST_RUN,  0);
    add("rl_e2",       1, 0, 0,  0, 0, 0,   0, ST_DONE, 1);
    add("rl_e3",       1, 0, 0,  0, 0, 0,   2, ST_RUN,  0);
    add("rl_e4",       1, 0, 0,  0, 0, 0,   1, ST_RUN,  0);
    add("rl_e5",       1, 0, 0,  0, 0, 0,   0, ST_DONE, 1);
    add("rl_e6",       1, 0, 0,  0, 0, 0,   2, ST_RUN,  0);
    add("rl_abort",    1, 0, 0,  0, 0, 1,   0, ST_IDLE, 0);
    // auto-reload of zero stays in DONE
    add("rz_start",    1, 0, 1,  0, 0, 0,   0, ST_DONE, 1);
    add("rz_again",    1, 0, 0,  0, 0, 0,   0, ST_DONE, 1);
    add("rz_abort",    1, 0, 0,  0, 0, 1,   0, ST_IDLE, 0);
    run_table();

    // Model-generated runs: a load of N gives count N-k on edge k and
    // done exactly on edge N; the maximum value is included.
    add("m_rst", 0, 1, 0, 0, 0, 0, 0, ST_IDLE, 0);
    ns[0] = (1 << W) - 1;
    ns[1] = $urandom_range(1, (1 << W) - 1);
    ns[2] = $urandom_range(1, (1 << W) - 1);
    for (int r = 0; r < 3; r++) begin
      n = ns[r];
      add($sformatf("m%0d_start", n), 0, 0, 1, n, 0, 0, n, ST_RUN, 0);
      for (int k = 1; k <= n; k++) begin
        add($sformatf("m%0d_e%0d", n, k), 0, 0, 0, 0, 0, 0, n - k,
            (k == n) ? ST_DONE : ST_RUN, (k == n));
      end
      add($sformatf("m%0d_idle", n), 0, 0, 0, 0, 0, 0, 0, ST_IDLE, 0);
    end
    run_table();

    @(negedge clk);
    rst = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
